// File: rtl/hatch_ctrl.sv
// Egg-hatch incubation sequencer: stage counter on a seconds timebase.
// Optional temperature-fault abort enabled by defining HATCH_TEMP_FAIL_EN.
module hatch_ctrl #(
  parameter int TICKS_PER_SEC  = 1000,
  parameter int SEC_PER_STAGE  = 3,
  parameter int MAX_STAGE      = 11,
  parameter int TEMP_FAULT_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic       temp,
  output logic [3:0] num,
  output logic       stage_pulse,
  output logic       busy,
  output logic       hatched,
  output logic       fail
);

  if (MAX_STAGE > 15 || MAX_STAGE < 1 || TICKS_PER_SEC < 1 ||
      SEC_PER_STAGE < 1 || TEMP_FAULT_SEC < 1) begin : g_bad_param
    $error("hatch_ctrl: illegal parameter values");
  end

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = (SEC_PER_STAGE > 1) ? $clog2(SEC_PER_STAGE) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(SEC_PER_STAGE - 1);
  localparam logic [3:0]    NUM_MAX  = 4'(MAX_STAGE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE,
    S_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    num_q, num_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          pulse_q, pulse_d;
  logic          busy_q, busy_d;
  logic          hatched_q, hatched_d;

  logic tick;
  logic sec_wrap;
  logic last_step;

  assign tick      = (pre_q == PRE_LAST);
  assign sec_wrap  = tick && (sec_q == SEC_LAST);
  assign last_step = (num_q == NUM_MAX - 4'd1);

`ifdef HATCH_TEMP_FAIL_EN
  localparam int FW = $clog2(TEMP_FAULT_SEC + 1);
  localparam logic [FW-1:0] FAULT_LIM = FW'(TEMP_FAULT_SEC);

  logic [FW-1:0] fault_q, fault_d;
  logic          fail_q, fail_d;
  logic          fault_trip;

  assign fault_trip = tick && (fault_q + 1'b1 == FAULT_LIM);
  assign fail       = fail_q;
`else
  assign fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (st) state_d = temp ? S_HOLD : S_RUN;
      end
      S_RUN: begin
        if (temp) begin
          state_d = S_HOLD;
        end else if (sec_wrap && last_step) begin
          state_d = S_DONE;
        end
      end
      S_HOLD: begin
        if (!temp) begin
          state_d = S_RUN;
`ifdef HATCH_TEMP_FAIL_EN
        end else if (fault_trip) begin
          state_d = S_FAIL;
`endif
        end
      end
      default: ;
    endcase
    // Dropping the enable overrides every other condition.
    if (!st) state_d = S_IDLE;
  end

  always_comb begin
    num_d     = num_q;
    pre_d     = pre_q;
    sec_d     = sec_q;
    pulse_d   = 1'b0;
    busy_d    = (state_q == S_RUN) || (state_q == S_HOLD);
    hatched_d = (state_q == S_DONE);
`ifdef HATCH_TEMP_FAIL_EN
    fault_d   = fault_q;
    fail_d    = (state_q == S_FAIL);
`endif
    if (!st) begin
      num_d = '0;
      pre_d = '0;
      sec_d = '0;
`ifdef HATCH_TEMP_FAIL_EN
      fault_d = '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          pre_d = '0;
          sec_d = '0;
        end
        S_RUN: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (!temp && tick) begin
            sec_d = sec_wrap ? '0 : sec_q + 1'b1;
            if (sec_wrap) begin
              num_d   = num_q + 4'd1;
              pulse_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
`ifdef HATCH_TEMP_FAIL_EN
          if (!temp) begin
            fault_d = '0;
          end else if (tick) begin
            fault_d = fault_q + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      num_q     <= '0;
      pre_q     <= '0;
      sec_q     <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      hatched_q <= 1'b0;
    end else begin
      num_q     <= num_d;
      pre_q     <= pre_d;
      sec_q     <= sec_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      hatched_q <= hatched_d;
    end
  end

`ifdef HATCH_TEMP_FAIL_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fault_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      fault_q <= fault_d;
      fail_q  <= fail_d;
    end
  end
`endif

  assign num         = num_q;
  assign stage_pulse = pulse_q;
  assign busy        = busy_q;
  assign hatched     = hatched_q;

endmodule

// File: tb/tb_hatch_ctrl.sv
// Directed bench for hatch_ctrl with a small timebase.
// Expectations track HATCH_TEMP_FAIL_EN when it is defined.
module tb_hatch_ctrl;

`ifdef HATCH_TEMP_FAIL_EN
  localparam int  HOLD_CYC = 8;
  localparam logic FAIL_EXP = 1'b1;
  localparam logic BUSY_FX  = 1'b0;
`else
  localparam int  HOLD_CYC = 20;
  localparam logic FAIL_EXP = 1'b0;
  localparam logic BUSY_FX  = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       st;
  logic       temp;
  logic [3:0] num;
  logic       stage_pulse;
  logic       busy;
  logic       hatched;
  logic       fail;

  int checks = 0;
  int errors = 0;

  hatch_ctrl #(
    .TICKS_PER_SEC (4),
    .SEC_PER_STAGE (2),
    .MAX_STAGE     (11),
    .TEMP_FAULT_SEC(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st         (st),
    .temp       (temp),
    .num        (num),
    .stage_pulse(stage_pulse),
    .busy       (busy),
    .hatched    (hatched),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b0;
    st   = 1'b1;
    temp = 1'b0;
    step(2);
    chk("rst_num", num, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_hatched", {3'b0, hatched}, 4'd0);
    chk("rst_fail", {3'b0, fail}, 4'd0);
    chk("rst_pulse", {3'b0, stage_pulse}, 4'd0);

    rst = 1'b1;
    step(1);
    step(1);
    chk("run_busy", {3'b0, busy}, 4'd1);
    step(6);
    chk("pre_step1_num", num, 4'd0);
    step(1);
    chk("step1_num", num, 4'd1);
    chk("step1_pulse", {3'b0, stage_pulse}, 4'd1);
    step(1);
    chk("step1_pulse_off", {3'b0, stage_pulse}, 4'd0);
    step(7);
    chk("step2_num", num, 4'd2);
    chk("step2_pulse", {3'b0, stage_pulse}, 4'd1);
    step(16);
    chk("step4_num", num, 4'd4);

    step(5);
    temp = 1'b1;
    for (int i = 0; i < HOLD_CYC; i++) begin
      step(1);
      chk("hold_num", num, 4'd4);
      chk("hold_pulse", {3'b0, stage_pulse}, 4'd0);
    end
    chk("hold_fail", {3'b0, fail}, 4'd0);
    temp = 1'b0;
    step(2);
    chk("resume_early", num, 4'd4);
    step(1);
    chk("resume_num", num, 4'd5);
    chk("resume_pulse", {3'b0, stage_pulse}, 4'd1);

    step(7);
    chk("wrap_pre", num, 4'd5);
    temp = 1'b1;
    step(1);
    chk("wrap_temp_num", num, 4'd5);
    chk("wrap_temp_pulse", {3'b0, stage_pulse}, 4'd0);
    temp = 1'b0;
    step(3);
    chk("wrap_resume_early", num, 4'd5);
    step(1);
    chk("wrap_resume_num", num, 4'd6);

    step(8);
    chk("abort_pre_num", num, 4'd7);
    st = 1'b0;
    step(1);
    chk("abort_num", num, 4'd0);
    st = 1'b1;
    step(1);
    chk("abort_busy", {3'b0, busy}, 4'd0);
    chk("abort_num2", num, 4'd0);
    step(7);
    chk("restart_early", num, 4'd0);
    step(1);
    chk("restart_num", num, 4'd1);
    chk("restart_pulse", {3'b0, stage_pulse}, 4'd1);

    step(32);
    chk("fault_start_num", num, 4'd5);
    temp = 1'b1;
    step(12);
    chk("fault_pre_flag", {3'b0, fail}, 4'd0);
    step(1);
    chk("fault_flag", {3'b0, fail}, {3'b0, FAIL_EXP});
    chk("fault_num", num, 4'd5);
    chk("fault_busy", {3'b0, busy}, {3'b0, BUSY_FX});
    temp = 1'b0;
    step(2);
    chk("fault_keep", {3'b0, fail}, {3'b0, FAIL_EXP});
    chk("fault_keep_num", num, 4'd5);
    st = 1'b0;
    step(2);
    chk("fault_clr_num", num, 4'd0);
    chk("fault_clr_flag", {3'b0, fail}, 4'd0);
    chk("fault_clr_busy", {3'b0, busy}, 4'd0);

    st = 1'b1;
    step(1);
    step(80);
    chk("full_num10", num, 4'd10);
    step(7);
    chk("full_pre_num", num, 4'd10);
    chk("full_pre_hatched", {3'b0, hatched}, 4'd0);
    step(1);
    chk("full_num11", num, 4'd11);
    chk("full_pulse", {3'b0, stage_pulse}, 4'd1);
    chk("full_hatched_lag", {3'b0, hatched}, 4'd0);
    step(1);
    chk("full_hatched", {3'b0, hatched}, 4'd1);
    chk("full_busy", {3'b0, busy}, 4'd0);
    chk("full_pulse_off", {3'b0, stage_pulse}, 4'd0);
    for (int i = 0; i < 6; i++) begin
      temp = ((i % 2) == 1);
      step(1);
      chk("done_toggle_num", num, 4'd11);
      chk("done_toggle_hatched", {3'b0, hatched}, 4'd1);
    end
    temp = 1'b0;
    step(20);
    chk("done_hold_num", num, 4'd11);

    rst = 1'b0;
    step(1);
    chk("final_rst_num", num, 4'd0);
    chk("final_rst_hatched", {3'b0, hatched}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
